// File: rtl/keypad_scanner_if.sv
// Keypad-side signal bundle for keypad_scanner: row sense in; column drive, key code and
// accept pulse out. The scanner uses the master modport; the keypad/consumer side uses slave.
interface keypad_scanner_if;
  logic [3:0] row;       // active-low rows from the keypad (asynchronous)
  logic [3:0] col;       // one-hot active-low column drive
  logic [3:0] value;     // code of the last accepted key
  logic       key_flag;  // single-cycle accept pulse

  modport master (
    input  row,
    output col,
    output value,
    output key_flag
  );

  modport slave (
    output row,
    input  col,
    input  value,
    input  key_flag
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix-keypad scanner with press and release debounce.
// Rotates an active-low column drive, samples the synchronized rows at the end of each
// column slot, debounces a detected pattern and emits one key_flag pulse with the key code.
// Optional auto-repeat while held is built only when KEYPAD_REPEAT_EN is defined.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CYC = 200000,
  parameter int unsigned REPEAT_DLY   = 5000000,
  parameter int unsigned REPEAT_PER   = 1000000
) (
  input logic              clk,
  input logic              rst,
  keypad_scanner_if.master kp
);

  localparam int unsigned MaxSd  = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
  localparam int unsigned MaxRp  = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned MaxCyc = (MaxSd > MaxRp) ? MaxSd : MaxRp;
  localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t ScanLast = cnt_t'(SCAN_DIV - 1);
  localparam cnt_t DebLast  = cnt_t'(DEBOUNCE_CYC - 1);
`ifdef KEYPAD_REPEAT_EN
  localparam cnt_t DlyLast  = cnt_t'(REPEAT_DLY - 1);
  localparam cnt_t PerLast  = cnt_t'(REPEAT_PER - 1);
`endif

  typedef enum logic [1:0] {StScan, StDebPress, StHeld, StDebRel} state_e;

  // Saturating increment: counters never wrap.
  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == '1) ? c : c + cnt_t'(1);
  endfunction

  // Lowest low row wins; column comes from the frozen one-hot drive.
  function automatic logic [3:0] key_code(input logic [3:0] col, input logic [3:0] pat);
    logic [1:0] r;
    logic [1:0] c;
    r = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!pat[i]) r = 2'(i);
    end
    c = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!col[i]) c = 2'(i);
    end
    case ({r, c})
      4'd0:  return 4'h1;
      4'd1:  return 4'h2;
      4'd2:  return 4'h3;
      4'd3:  return 4'hA;
      4'd4:  return 4'h4;
      4'd5:  return 4'h5;
      4'd6:  return 4'h6;
      4'd7:  return 4'hB;
      4'd8:  return 4'h7;
      4'd9:  return 4'h8;
      4'd10: return 4'h9;
      4'd11: return 4'hC;
      4'd12: return 4'hE;
      4'd13: return 4'h0;
      4'd14: return 4'hF;
      4'd15: return 4'hD;
    endcase
  endfunction

  logic [3:0] row_s1_q, row_s2_q;
  state_e     state_q, state_d;
  logic [3:0] col_q, col_d;
  logic [3:0] pat_q, pat_d;
  logic [3:0] value_q, value_d;
  logic       flag_q, flag_d;
  cnt_t       scan_cnt_q, scan_cnt_d;
  cnt_t       deb_cnt_q, deb_cnt_d;
`ifdef KEYPAD_REPEAT_EN
  cnt_t       rep_cnt_q, rep_cnt_d;
  logic       rep_first_q, rep_first_d;
`endif

  logic [3:0] row;
  logic [3:0] col_rot;
  assign row     = row_s2_q;
  assign col_rot = {col_q[2:0], col_q[3]};

  // Two-stage synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
    end else begin
      row_s1_q <= kp.row;
      row_s2_q <= row_s1_q;
    end
  end

  // Next-state logic: scan, debounce press, hold (optional repeat), debounce release.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    pat_d      = pat_q;
    value_d    = value_q;
    flag_d     = 1'b0;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
`endif
    unique case (state_q)
      StScan: begin
        if (scan_cnt_q >= ScanLast) begin
          scan_cnt_d = '0;
          if (row != 4'hF) begin
            pat_d     = row;
            deb_cnt_d = '0;
            state_d   = StDebPress;
          end else begin
            col_d = col_rot;
          end
        end else begin
          scan_cnt_d = sat_inc(scan_cnt_q);
        end
      end
      StDebPress: begin
        if (row != pat_q) begin
          col_d      = col_rot;
          scan_cnt_d = '0;
          state_d    = StScan;
        end else if (deb_cnt_q >= DebLast) begin
          flag_d  = 1'b1;
          value_d = key_code(col_q, pat_q);
          state_d = StHeld;
`ifdef KEYPAD_REPEAT_EN
          rep_cnt_d   = '0;
          rep_first_d = 1'b1;
`endif
        end else begin
          deb_cnt_d = sat_inc(deb_cnt_q);
        end
      end
      StHeld: begin
        if (row == 4'hF) begin
          deb_cnt_d = '0;
          state_d   = StDebRel;
        end
`ifdef KEYPAD_REPEAT_EN
        // Only an unchanged pattern builds toward a repeat.
        else if (row != pat_q) begin
          rep_cnt_d = '0;
        end else if (rep_cnt_q >= (rep_first_q ? DlyLast : PerLast)) begin
          flag_d      = 1'b1;
          rep_cnt_d   = '0;
          rep_first_d = 1'b0;
        end else begin
          rep_cnt_d = sat_inc(rep_cnt_q);
        end
`endif
      end
      StDebRel: begin
        if (row != 4'hF) begin
          state_d = StHeld;
`ifdef KEYPAD_REPEAT_EN
          rep_cnt_d   = '0;
          rep_first_d = 1'b1;
`endif
        end else if (deb_cnt_q >= DebLast) begin
          col_d      = col_rot;
          scan_cnt_d = '0;
          state_d    = StScan;
        end else begin
          deb_cnt_d = sat_inc(deb_cnt_q);
        end
      end
      default: state_d = StScan;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StScan;
      col_q      <= 4'b1110;
      pat_q      <= 4'hF;
      value_q    <= 4'h0;
      flag_q     <= 1'b0;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      pat_q      <= pat_d;
      value_q    <= value_d;
      flag_q     <= flag_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
`endif
    end
  end

  assign kp.col      = col_q;
  assign kp.value    = value_q;
  assign kp.key_flag = flag_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural 4x4 keypad model.
// Repeat expectations follow KEYPAD_REPEAT_EN, matching the DUT build.
module tb_keypad_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;

  keypad_scanner_if kp ();

  keypad_scanner #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CYC(16),
    .REPEAT_DLY  (64),
    .REPEAT_PER  (32)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .kp (kp)
  );

  always #5 clk = ~clk;

  // Keypad model: key index r*4+c pulls row r low while column c is driven low.
  logic [15:0] pressed = '0;
  logic [3:0]  row_v;
  always_comb begin
    row_v = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !kp.col[c]) row_v[r] = 1'b0;
      end
    end
  end
  assign kp.row = row_v;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse monitor and output-rule watchers.
  int         cyc = 0;
  logic       rst_seen = 1'b1;
  int         n_pulse = 0;
  int         n_consec = 0;
  int         n_badval = 0;
  int         pulse_t[$];
  logic       prev_flag = 1'b0;
  logic [3:0] prev_value = 4'h0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  always @(negedge clk) begin
    if (kp.key_flag === 1'b1) begin
      n_pulse++;
      pulse_t.push_back(cyc);
      if (prev_flag) n_consec++;
    end
    if (kp.value !== prev_value && kp.key_flag !== 1'b1 && !rst_seen) n_badval++;
    prev_flag  = kp.key_flag;
    prev_value = kp.value;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pulse(input string tag, input int bound);
    int start;
    int k;
    start = n_pulse;
    k = 0;
    while (n_pulse == start && k < bound) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, 32'(n_pulse > start), 32'd1);
  endtask

  task automatic wait_col(input string tag, input logic [3:0] c, input int bound);
    int k;
    k = 0;
    while (kp.col !== c && k < bound) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, 32'(kp.col), 32'(c));
  endtask

  task automatic seen_cols(input int n, output logic [3:0] seen);
    seen = '0;
    repeat (n) begin
      @(negedge clk);
      case (kp.col)
        4'b1110: seen[0] = 1'b1;
        4'b1101: seen[1] = 1'b1;
        4'b1011: seen[2] = 1'b1;
        4'b0111: seen[3] = 1'b1;
        default: ;
      endcase
    end
  endtask

  initial begin
    int         n0;
    int         t0;
    int         k;
    logic [3:0] seen;

    // 1. Reset values, then idle scanning.
    tick(3);
    rst = 1'b0;
    check_eq("rst_col", 32'(kp.col), 32'h E);
    check_eq("rst_value", 32'(kp.value), 32'h0);
    check_eq("rst_flag", 32'(kp.key_flag), 32'h0);
    n0 = n_pulse;
    seen_cols(100, seen);
    check_eq("idle_cols", 32'(seen), 32'hF);
    check_eq("idle_pulses", 32'(n_pulse - n0), 32'd0);

    // 2. Hold '5' (row1, col1).
    n0 = n_pulse;
    pressed[5] = 1'b1;
    wait_pulse("k5_accept", 100);
    check_eq("k5_value", 32'(kp.value), 32'h5);
    tick(40);
    check_eq("k5_col_held", 32'(kp.col), 32'hD);
    check_eq("k5_one_pulse", 32'(n_pulse - n0), 32'd1);
    pressed = '0;
    tick(10);
    check_eq("k5_col_deb_rel", 32'(kp.col), 32'hD);
    k = 0;
    while (kp.col === 4'b1101 && k < 30) begin
      @(negedge clk);
      k++;
    end
    check_eq("k5_col_resume", 32'(kp.col != 4'b1101), 32'd1);
    check_eq("k5_total", 32'(n_pulse - n0), 32'd1);

    // 3. '9' bounced for 10 cycles only.
    n0 = n_pulse;
    pressed[10] = 1'b1;
    tick(10);
    pressed = '0;
    tick(40);
    check_eq("k9_no_pulse", 32'(n_pulse - n0), 32'd0);
    seen_cols(40, seen);
    check_eq("k9_scan_resume", 32'(seen), 32'hF);
    check_eq("k9_value_kept", 32'(kp.value), 32'h5);

    // 4. '*' and 'D' together, pressed at the start of the col0 slot.
    wait_col("k4_align_a", 4'b0111, 40);
    wait_col("k4_align_b", 4'b1110, 10);
    n0 = n_pulse;
    pressed[12] = 1'b1;
    pressed[15] = 1'b1;
    wait_pulse("k4_accept", 100);
    check_eq("k4_value", 32'(kp.value), 32'hE);
    check_eq("k4_col", 32'(kp.col), 32'hE);
    tick(20);
    pressed = '0;
    tick(5);
    pressed[12] = 1'b1;
    pressed[15] = 1'b1;
    tick(3);
    pressed = '0;
    tick(40);
    check_eq("k4_one_pulse", 32'(n_pulse - n0), 32'd1);
    check_eq("k4_value_kept", 32'(kp.value), 32'hE);

    // 5. Reset during press debounce of '0' (row3, col1).
    wait_col("k0_align_a", 4'b0111, 40);
    wait_col("k0_align_b", 4'b1110, 10);
    n0 = n_pulse;
    pressed[13] = 1'b1;
    tick(12);
    check_eq("k0_col_frozen", 32'(kp.col), 32'hD);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("k0_rst_col", 32'(kp.col), 32'hE);
    check_eq("k0_rst_value", 32'(kp.value), 32'h0);
    check_eq("k0_rst_flag", 32'(kp.key_flag), 32'h0);
    check_eq("k0_no_pulse", 32'(n_pulse - n0), 32'd0);
    wait_pulse("k0_accept", 100);
    check_eq("k0_value", 32'(kp.value), 32'h0);
    tick(30);
    check_eq("k0_one_pulse", 32'(n_pulse - n0), 32'd1);
    pressed = '0;
    tick(40);

    // 6. Hold 'A' (row0, col3) long enough for several repeat periods.
    n0 = n_pulse;
    pressed[3] = 1'b1;
    wait_pulse("kA_accept", 100);
    check_eq("kA_value", 32'(kp.value), 32'hA);
    t0 = (pulse_t.size() > n0) ? pulse_t[n0] : 0;
    tick(170);
    pressed = '0;
    tick(40);
`ifdef KEYPAD_REPEAT_EN
    check_eq("kA_count", 32'(n_pulse - n0), 32'd5);
    for (int i = 1; i <= 4; i++) begin
      int dt;
      dt = (pulse_t.size() > n0 + i) ? pulse_t[n0+i] - t0 : -1;
      check_eq($sformatf("kA_rep%0d_time", i), 32'(dt), 32'(32 + 32 * i));
    end
`else
    check_eq("kA_count", 32'(n_pulse - n0), 32'd1);
`endif
    check_eq("kA_value_end", 32'(kp.value), 32'hA);

    // Global output rules.
    check_eq("no_consec_flags", 32'(n_consec), 32'd0);
    check_eq("value_only_with_flag", 32'(n_badval), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
